// File: rtl/instruction_fetch_queued.sv
// Fetch stage: PC, synchronous word-addressed imem and a prefetch queue feeding decode (valid/ready).
// Define IF_FETCH_COUNT_EN to add the 32-bit fetch_count output counting accepted instructions.
module instruction_fetch_queued #(
  parameter int                INSTR_W  = 16,
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_stall,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic               load_we,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0]        fetch_count
`endif
);

  localparam int PW    = $clog2(FQ_DEPTH);
  localparam int CW    = PW + 1;
  localparam int OCC_W = CW + 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FQ_DEPTH);

  logic [INSTR_W-1:0] mem     [2**ADDR_W];
  logic [INSTR_W-1:0] q_instr [FQ_DEPTH];
  logic [ADDR_W-1:0]  q_pc    [FQ_DEPTH];
  logic [INSTR_W-1:0] rdata;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic [ADDR_W-1:0]  pc, inflight_pc;
  logic               inflight;
  logic               issue, push, pop;
  logic [OCC_W-1:0]   occ;

  // Occupancy counts the in-flight read so the queue can never be over-committed.
  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    push      = inflight & ~redir_valid;
    occ       = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
    issue     = ~fetch_stall & ~redir_valid & (occ < DEPTH_V);
    out_instr = out_valid ? q_instr[rd_ptr] : '0;
    out_pc    = out_valid ? q_pc[rd_ptr] : '0;
  end

  // Non-blocking read and write of the same word give read-first behaviour.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (issue)   rdata <= mem[pc];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redir_valid) begin
      pc       <= redir_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(1);
        inflight_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  // Counts decode handshakes; a redirect does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_queued.sv
// Self-checking bench for instruction_fetch_queued: vector table, corner-case sequences, random vs queue model.
// Honours IF_FETCH_COUNT_EN by also checking fetch_count.
module tb_instruction_fetch_queued;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               fetch_stall;
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_pc;
  logic               load_we;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0]        fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch_queued #(
    .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_PC(5'd0), .FQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .fetch_stall(fetch_stall),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef IF_FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of fetched {pc, instr} records plus one pending read.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } qent_t;

  qent_t              mq[$];
  logic [INSTR_W-1:0] mmem [32];
  bit                 mpend;
  logic [ADDR_W-1:0]  mpend_pc;
  logic [INSTR_W-1:0] mpend_instr;
  logic [ADDR_W-1:0]  mpc;
  logic [31:0]        mcnt;

  typedef struct {
    bit                 rst;
    bit                 stall;
    bit                 redir;
    logic [ADDR_W-1:0]  rpc;
    bit                 ready;
    bit                 ev;
    logic [ADDR_W-1:0]  epc;
    logic [INSTR_W-1:0] einstr;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [INSTR_W-1:0] progWord(input int i);
    if (i < 4) return 16'(16'h1111 * (i + 1));
    return 16'(16'hC000 + i);
  endfunction

  task automatic modelReset();
    mq.delete();
    mpend       = 1'b0;
    mpend_pc    = '0;
    mpend_instr = '0;
    mpc         = 5'd0;
    mcnt        = '0;
  endtask

  // Called just after each rising edge with the inputs that edge sampled.
  task automatic modelStep();
    bit pop;
    int occ;
    pop = (mq.size() != 0) && out_ready;
    if (!reset) begin
      modelReset();
    end else begin
      if (pop) mcnt = mcnt + 32'd1;
      if (redir_valid) begin
        mq.delete();
        mpend = 1'b0;
        mpc   = redir_pc;
      end else begin
        occ = int'(mq.size()) + int'(mpend) - int'(pop);
        if (pop)   void'(mq.pop_front());
        if (mpend) mq.push_back(qent_t'{mpend_pc, mpend_instr});
        if (!fetch_stall && occ < DEPTH) begin
          mpend       = 1'b1;
          mpend_pc    = mpc;
          mpend_instr = mmem[mpc];
          mpc         = mpc + 5'd1;
        end else begin
          mpend = 1'b0;
        end
      end
    end
    if (load_we) mmem[load_addr] = load_data;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit stall, input bit redir,
                               input logic [ADDR_W-1:0] rpc, input bit rdy, input bit we,
                               input logic [ADDR_W-1:0] wa, input logic [INSTR_W-1:0] wd);
    @(negedge clk);
    reset       = rst;
    fetch_stall = stall;
    redir_valid = redir;
    redir_pc    = rpc;
    out_ready   = rdy;
    load_we     = we;
    load_addr   = wa;
    load_data   = wd;
    if (!rst) modelReset();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit ev;
    ev = (mq.size() != 0);
    cmp({tag, ":valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      cmp({tag, ":pc"},    32'(out_pc),    32'(mq[0].pc));
      cmp({tag, ":instr"}, 32'(out_instr), 32'(mq[0].instr));
    end
`ifdef IF_FETCH_COUNT_EN
    cmp({tag, ":count"}, fetch_count, mcnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    int lastAcc, lastBefore, resumed, got, gotInstr;
    bit sawWrap, sawDrop;
    logic [ADDR_W-1:0]  colAddr;
    logic [INSTR_W-1:0] oldWord;

    // Rows are {rst, stall, redir, rpc, ready, exp_valid, exp_pc, exp_instr}.
    vecs[0]  = '{1, 0, 0, 5'd0,  1, 0, 5'd0,  16'h0000};
    vecs[1]  = '{1, 0, 0, 5'd0,  1, 0, 5'd0,  16'h0000};
    vecs[2]  = '{1, 0, 0, 5'd0,  1, 1, 5'd0,  16'h1111};
    vecs[3]  = '{1, 0, 0, 5'd0,  1, 1, 5'd1,  16'h2222};
    vecs[4]  = '{1, 0, 0, 5'd0,  1, 1, 5'd2,  16'h3333};
    vecs[5]  = '{1, 0, 1, 5'd20, 0, 1, 5'd3,  16'h4444};
    vecs[6]  = '{1, 0, 0, 5'd0,  1, 0, 5'd0,  16'h0000};
    vecs[7]  = '{1, 0, 0, 5'd0,  1, 0, 5'd0,  16'h0000};
    vecs[8]  = '{1, 0, 0, 5'd0,  1, 1, 5'd20, 16'hC014};
    vecs[9]  = '{1, 0, 0, 5'd0,  1, 1, 5'd21, 16'hC015};
    vecs[10] = '{1, 0, 0, 5'd0,  0, 1, 5'd22, 16'hC016};
    vecs[11] = '{1, 0, 0, 5'd0,  0, 1, 5'd22, 16'hC016};
    vecs[12] = '{0, 0, 0, 5'd0,  0, 0, 5'd0,  16'h0000};
    vecs[13] = '{1, 0, 0, 5'd0,  0, 0, 5'd0,  16'h0000};
    vecs[14] = '{1, 0, 0, 5'd0,  0, 0, 5'd0,  16'h0000};
    for (int r = 15; r <= 18; r++) vecs[r] = '{1, 0, 0, 5'd0, 0, 1, 5'd0, 16'h1111};
    vecs[19] = '{1, 0, 0, 5'd0,  1, 1, 5'd0,  16'h1111};
    vecs[20] = '{1, 0, 0, 5'd0,  1, 1, 5'd1,  16'h2222};
    vecs[21] = '{1, 0, 0, 5'd0,  1, 1, 5'd2,  16'h3333};
    vecs[22] = '{1, 0, 0, 5'd0,  1, 1, 5'd3,  16'h4444};
    vecs[23] = '{1, 0, 0, 5'd0,  1, 1, 5'd4,  16'hC004};

    reset = 1'b0; fetch_stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    out_ready = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    modelReset();
    for (int i = 0; i < 32; i++) mmem[i] = '0;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 5'd0, 0, 1, 5'(i), progWord(i));
      tick();
    end
    applyStimulus(0, 0, 0, 5'd0, 0, 0, 5'd0, 16'h0);
    checkOutput("reset");
    cmp("reset_valid", 32'(out_valid), 32'd0);
    cmp("reset_instr", 32'(out_instr), 32'd0);
    cmp("reset_pc",    32'(out_pc),    32'd0);
    tick();

    for (int r = 0; r < 24; r++) begin
      applyStimulus(vecs[r].rst, vecs[r].stall, vecs[r].redir, vecs[r].rpc, vecs[r].ready,
                    0, 5'd0, 16'h0);
      checkOutput($sformatf("vec%0d", r));
      cmp($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(vecs[r].ev));
      if (vecs[r].ev || !vecs[r].rst) begin
        cmp($sformatf("vec%0d_pc", r),    32'(out_pc),    32'(vecs[r].epc));
        cmp($sformatf("vec%0d_instr", r), 32'(out_instr), 32'(vecs[r].einstr));
      end
      tick();
    end

    // PC wrap from 31 to 0.
    lastAcc = -1; sawWrap = 1'b0;
    applyStimulus(1, 0, 1, 5'd30, 1, 0, 5'd0, 16'h0);
    checkOutput("wrap_redir");
    tick();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, 0, 0, 5'd0, 1, 0, 5'd0, 16'h0);
      checkOutput("wrap");
      if (out_valid) begin
        if (lastAcc == 31 && out_pc == 5'd0) sawWrap = 1'b1;
        lastAcc = int'(out_pc);
      end
      tick();
    end
    cmp("wrap_31_to_0", 32'(sawWrap), 32'd1);

    // Three stall cycles drain the queue; fetch resumes at the next sequential pc.
    sawDrop = 1'b0; resumed = -1; lastBefore = lastAcc;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, c < 3, 0, 5'd0, 1, 0, 5'd0, 16'h0);
      checkOutput("stall");
      if (!out_valid) sawDrop = 1'b1;
      else if (!sawDrop) lastBefore = int'(out_pc);
      else if (resumed < 0) resumed = int'(out_pc);
      tick();
    end
    cmp("stall_drop", 32'(sawDrop), 32'd1);
    cmp("stall_resume_pc", 32'(resumed), 32'((lastBefore + 1) % 32));

    // Redirect while stalled: first instruction after release comes from the target.
    got = -1;
    applyStimulus(1, 1, 1, 5'd10, 1, 0, 5'd0, 16'h0);
    checkOutput("redir_stall");
    tick();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1, c < 2, 0, 5'd0, 1, 0, 5'd0, 16'h0);
      checkOutput("redir_stall_run");
      if (out_valid && got < 0) got = int'(out_pc);
      tick();
    end
    cmp("redir_stall_pc", 32'(got), 32'd10);

    // Load write to the word being read this cycle returns the old word.
    colAddr = mpc; oldWord = mmem[mpc]; gotInstr = -1;
    applyStimulus(1, 0, 0, 5'd0, 1, 1, colAddr, 16'hBEEF);
    checkOutput("collide");
    tick();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 0, 0, 5'd0, 1, 0, 5'd0, 16'h0);
      checkOutput("collide_run");
      if (out_valid && out_pc == colAddr && gotInstr < 0) gotInstr = int'(out_instr);
      tick();
    end
    cmp("read_first", 32'(gotInstr), 32'(oldWord));

    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 19) == 0, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                    5'($urandom_range(0, 31)), 16'($urandom()));
      checkOutput($sformatf("rand%0d", c));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
